// File: rtl/req_code_encoder_pkg.sv
// Shared types, sizing and bit-vector helpers for the request-to-code encoder.
package enc_pkg;

    localparam int NREQ     = 8;
    localparam int CODE_W   = $clog2(NREQ);
    localparam int CODE_MAX = 5;

    typedef enum logic {IDLE, EMIT} enc_state_t;

    // Scan from the top so the lowest set index is the last one written.
    function automatic logic [CODE_W-1:0] lowest_set_idx(input logic [NREQ-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    function automatic logic onehot0(input logic [NREQ-1:0] vec);
        return (vec & (vec - NREQ'(1))) == '0;
    endfunction

endpackage

// File: rtl/req_code_encoder_if.sv
// Request-vector and code-bus handshake bundle between aggregator, encoder and decoder.
interface req_code_encoder_if;
    import enc_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [NREQ-1:0]   req_vec;
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code;
    logic              code_last;
    logic              zero_req;
    logic [7:0]        code_cnt;
    logic              range_err;

    modport master (
        output req_valid, req_vec, code_ready,
        input  req_ready, code_valid, code, code_last, zero_req, code_cnt, range_err
    );

    modport slave (
        input  req_valid, req_vec, code_ready,
        output req_ready, code_valid, code, code_last, zero_req, code_cnt, range_err
    );

endinterface

// File: rtl/req_code_encoder_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder: vector in, index and any-set flag out.
module lsb_prio_enc
    import enc_pkg::*;
(
    input  logic [NREQ-1:0]   vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o
);

    assign idx_o = lowest_set_idx(vec_i);
    assign any_o = |vec_i;

endmodule

// File: rtl/req_code_encoder.sv
// Serialises an accepted request vector into binary codes, lowest index first.
// Optional macro CODE_RANGE_CHK_EN masks bits above CODE_MAX and flags them on range_err.
module req_code_encoder
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    req_code_encoder_if.slave  bus
);

    enc_state_t        state_q, state_d;
    logic [NREQ-1:0]   pending_q, pending_d, masked_vec;
    logic [CODE_W-1:0] code_q, code_d, low_idx;
    logic [7:0]        code_cnt_q, code_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              code_valid_q, code_valid_d;
    logic              code_last_q, code_last_d;
    logic              zero_req_q, zero_req_d;
    logic              range_err_q, range_err_d;
    logic              pend_any, accept, handshake;

    assign accept    = bus.req_valid && req_ready_q;
    assign handshake = code_valid_q && bus.code_ready;

`ifdef CODE_RANGE_CHK_EN
    localparam logic [NREQ-1:0] RANGE_MASK = NREQ'((1 << (CODE_MAX + 1)) - 1);
    assign masked_vec  = bus.req_vec & RANGE_MASK;
    assign range_err_d = accept && |(bus.req_vec & ~RANGE_MASK);
`else
    assign masked_vec  = bus.req_vec;
    assign range_err_d = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        code_cnt_d = code_cnt_q;
        zero_req_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d  = masked_vec;
                    zero_req_d = (masked_vec == '0);
                    if (masked_vec != '0) state_d = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    pending_d  = pending_q & ~(NREQ'(1) << code_q);
                    code_cnt_d = code_cnt_q + 8'd1;
                    if (code_last_q) state_d = IDLE;
                end
            end
        endcase
    end

    lsb_prio_enc u_prio_enc (
        .vec_i (pending_d),
        .idx_o (low_idx),
        .any_o (pend_any)
    );

    // Outputs are computed from next state so they can be registered without adding latency.
    always_comb begin
        code_d       = low_idx;
        code_valid_d = (state_d == EMIT);
        code_last_d  = pend_any && onehot0(pending_d);
        req_ready_d  = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            code_q       <= '0;
            code_cnt_q   <= '0;
            req_ready_q  <= 1'b1;
            code_valid_q <= 1'b0;
            code_last_q  <= 1'b0;
            zero_req_q   <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            code_q       <= code_d;
            code_cnt_q   <= code_cnt_d;
            req_ready_q  <= req_ready_d;
            code_valid_q <= code_valid_d;
            code_last_q  <= code_last_d;
            zero_req_q   <= zero_req_d;
            range_err_q  <= range_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code       = code_q;
    assign bus.code_last  = code_last_q;
    assign bus.zero_req   = zero_req_q;
    assign bus.code_cnt   = code_cnt_q;
    assign bus.range_err  = range_err_q;

endmodule

// File: tb/tb_req_code_encoder.sv
// Directed, table-driven bench for req_code_encoder; expectations follow CODE_RANGE_CHK_EN when defined.
module tb_req_code_encoder;

    typedef struct {
        logic [7:0]  vec;
        int          n;
        logic [23:0] codes;
        logic        rerr;
    } vec_rec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] exp_cnt;
    vec_rec_t   tbl[6];
    vec_rec_t   rec_3f, rec_01, rec_10;

    req_code_encoder_if bus ();

    req_code_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Applies one vector with code_ready held high; called on a falling edge in IDLE.
    task automatic run_vec(input vec_rec_t r);
        check("pre_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_vec    = r.vec;
        bus.code_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("zero_req_pulse", 32'(bus.zero_req), 32'(r.n == 0));
        check("range_err_pulse", 32'(bus.range_err), 32'(r.rerr));
        for (int k = 0; k < r.n; k++) begin
            check("code_valid", 32'(bus.code_valid), 32'd1);
            check("code", 32'(bus.code), 32'(r.codes[3*k +: 3]));
            check("code_last", 32'(bus.code_last), 32'(k == r.n - 1));
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check("end_valid", 32'(bus.code_valid), 32'd0);
        check("end_ready", 32'(bus.req_ready), 32'd1);
        if (r.n == 0) @(negedge clk);
        check("zero_req_clear", 32'(bus.zero_req), 32'd0);
        check("range_err_clear", 32'(bus.range_err), 32'd0);
        exp_cnt = exp_cnt + 8'(r.n);
        check("code_cnt", 32'(bus.code_cnt), 32'(exp_cnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 8'd0;

        tbl[0] = '{vec: 8'b0010_0110, n: 3, codes: {15'b0, 3'd5, 3'd2, 3'd1}, rerr: 1'b0};
        tbl[1] = '{vec: 8'h00, n: 0, codes: 24'd0, rerr: 1'b0};
`ifdef CODE_RANGE_CHK_EN
        tbl[2] = '{vec: 8'b1100_0001, n: 1, codes: 24'd0, rerr: 1'b1};
        tbl[3] = '{vec: 8'h80, n: 0, codes: 24'd0, rerr: 1'b1};
        tbl[5] = '{vec: 8'hFF, n: 6, codes: {6'b0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, rerr: 1'b1};
`else
        tbl[2] = '{vec: 8'b1100_0001, n: 3, codes: {15'b0, 3'd7, 3'd6, 3'd0}, rerr: 1'b0};
        tbl[3] = '{vec: 8'h80, n: 1, codes: {21'b0, 3'd7}, rerr: 1'b0};
        tbl[5] = '{vec: 8'hFF, n: 8, codes: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, rerr: 1'b0};
`endif
        tbl[4] = '{vec: 8'h3F, n: 6, codes: {6'b0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, rerr: 1'b0};
        rec_3f = tbl[4];
        rec_01 = '{vec: 8'h01, n: 1, codes: 24'd0, rerr: 1'b0};
        rec_10 = '{vec: 8'h10, n: 1, codes: {21'b0, 3'd4}, rerr: 1'b0};

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_vec    = 8'h00;
        bus.code_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_code_valid", 32'(bus.code_valid), 32'd0);
        check("rst_code", 32'(bus.code), 32'd0);
        check("rst_code_last", 32'(bus.code_last), 32'd0);
        check("rst_zero_req", 32'(bus.zero_req), 32'd0);
        check("rst_code_cnt", 32'(bus.code_cnt), 32'd0);
        check("rst_range_err", 32'(bus.range_err), 32'd0);
        @(negedge clk);
        check("idle_valid", 32'(bus.code_valid), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Stall: code must hold while code_ready is low; a new request in EMIT is ignored.
        bus.req_valid  = 1'b1;
        bus.req_vec    = 8'h01;
        bus.code_ready = 1'b0;
        @(negedge clk);
        bus.req_vec = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(bus.code_valid), 32'd1);
            check("stall_code", 32'(bus.code), 32'd0);
            check("stall_last", 32'(bus.code_last), 32'd1);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.code_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        check("stall_done_valid", 32'(bus.code_valid), 32'd0);
        check("stall_done_ready", 32'(bus.req_ready), 32'd1);
        check("stall_done_cnt", 32'(bus.code_cnt), 32'(exp_cnt));
        @(negedge clk);
        check("stall_no_late_accept", 32'(bus.code_valid), 32'd0);

        // Reset after the first of codes {3,4}.
        bus.req_valid = 1'b1;
        bus.req_vec   = 8'h18;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_code3", 32'(bus.code), 32'd3);
        @(negedge clk);
        check("mid_code4", 32'(bus.code), 32'd4);
        check("mid_valid", 32'(bus.code_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.code_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_code", 32'(bus.code), 32'd0);
        check("mid_rst_last", 32'(bus.code_last), 32'd0);
        check("mid_rst_cnt", 32'(bus.code_cnt), 32'd0);
        exp_cnt = 8'd0;
        run_vec(rec_10);

        // 1 + 42*6 + 3 = 256 codes since reset, so the counter wraps to 0.
        for (int i = 0; i < 42; i++) run_vec(rec_3f);
        run_vec(rec_01);
        run_vec(rec_01);
        check("cnt_255", 32'(bus.code_cnt), 32'd255);
        run_vec(rec_01);
        check("cnt_wrap", 32'(bus.code_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
